// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, uo_out bit positions, Bayer threshold lookup
//   and the stage-1 pipeline record used by the pixel output stage.
package vga_pkg;

    localparam int H_DISPLAY = 1220;
    localparam int H_TOTAL   = 1525;
    localparam int V_DISPLAY = 480;
    localparam int V_TOTAL   = 525;

    // uo_out = {hsync_n, B0, G0, R0, vsync_n, B1, G1, R1}
    localparam int UO_HSYNC = 7;
    localparam int UO_B0    = 6;
    localparam int UO_G0    = 5;
    localparam int UO_R0    = 4;
    localparam int UO_VSYNC = 3;
    localparam int UO_B1    = 2;
    localparam int UO_G1    = 1;
    localparam int UO_R1    = 0;

    // 4x4 ordered-dither thresholds, nibble index {by, bx}, entry 0 in the LSBs
    localparam logic [63:0] BAYER = {
        4'd5, 4'd13, 4'd7,  4'd15,
        4'd9, 4'd1,  4'd11, 4'd3,
        4'd6, 4'd14, 4'd4,  4'd12,
        4'd10, 4'd2, 4'd8,  4'd0
    };

    function automatic logic [3:0] bayer4(input logic [1:0] bx, input logic [1:0] by);
        return BAYER[{by, bx, 2'b00} +: 4];
    endfunction

    typedef struct packed {
        logic       vis;
        logic       active;
        logic       chk;
        logic       hs;
        logic       vs;
        logic [5:0] luma;
        logic [1:0] bx;
        logic [1:0] by;
    } stage1_t;

    localparam stage1_t S1_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

endpackage

// File: rtl/donut_pixel_out_if.sv
// donut_pixel_out_if: raster/renderer inputs and PMOD output word of the pixel output stage.
//   h_count[10:0], v_count[9:0], hsync_n, vsync_n  raster timing (sync active-low)
//   donut_visible, donut_luma[5:0]                 held renderer sample
//   uo_out[7:0]                                    registered VGA PMOD word
//   master: drives raster/renderer, reads uo_out; slave: the output stage.
interface donut_pixel_out_if;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        hsync_n;
    logic        vsync_n;
    logic        donut_visible;
    logic [5:0]  donut_luma;
    logic [7:0]  uo_out;

    modport master (output h_count, v_count, hsync_n, vsync_n, donut_visible, donut_luma,
                    input  uo_out);
    modport slave  (input  h_count, v_count, hsync_n, vsync_n, donut_visible, donut_luma,
                    output uo_out);
endinterface

// File: rtl/donut_pixel_out_bayer_dither.sv
// bayer_dither: combinational 6-bit to 2-bit ordered dither.
//   luma[5:0] in, bx/by[1:0] matrix position in, lvl[1:0] out (saturates at 3).
module bayer_dither
    import vga_pkg::*;
(
    input  logic [5:0] luma,
    input  logic [1:0] bx,
    input  logic [1:0] by,
    output logic [1:0] lvl
);

    always_comb lvl = (luma[3:0] > bayer4(bx, by) && luma[5:4] != 2'd3) ? luma[5:4] + 2'd1 : luma[5:4];

endmodule

// File: rtl/donut_pixel_out.sv
// donut_pixel_out: two-stage dither/background/blanking pipeline producing the VGA PMOD word.
//   clk, rst_n (synchronous, active-low)
//   bus (slave): h_count, v_count, hsync_n, vsync_n, donut_visible, donut_luma in; uo_out out
module donut_pixel_out #(
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int H_TOTAL   = vga_pkg::H_TOTAL,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int V_TOTAL   = vga_pkg::V_TOTAL
) (
    input logic              clk,
    input logic              rst_n,
    donut_pixel_out_if.slave bus
);
    import vga_pkg::*;

    // The last 8 visible columns are never donut: the renderer's held value there is stale.
    localparam logic [10:0] H_GUARD = 11'(H_DISPLAY - 8);
    localparam logic [10:0] H_ACT   = 11'(H_DISPLAY);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_DISPLAY);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

    stage1_t    s1_q, s1_d;
    logic [4:0] scroll_q, scroll_d;
    logic [7:0] uo_q, uo_d;
    logic [1:0] lvl, r, g, b;

    bayer_dither u_dither (
        .luma (s1_q.luma),
        .bx   (s1_q.bx),
        .by   (s1_q.by),
        .lvl  (lvl)
    );

    always_comb begin
        s1_d.vis    = bus.donut_visible && bus.h_count < H_GUARD;
        s1_d.active = bus.h_count < H_ACT && bus.v_count < V_ACT;
        // Only bit 0 of the scrolled column index selects the checker phase
        s1_d.chk    = 1'(bus.h_count[9:5] + scroll_q) ^ bus.v_count[5];
        s1_d.hs     = bus.hsync_n;
        s1_d.vs     = bus.vsync_n;
        s1_d.luma   = bus.donut_luma;
        s1_d.bx     = bus.h_count[3:2];
        s1_d.by     = bus.v_count[1:0];
        scroll_d    = (bus.h_count == H_LAST && bus.v_count == V_LAST) ? scroll_q + 5'd1 : scroll_q;
        r = !s1_q.active ? 2'd0 : s1_q.vis ? lvl : 2'd0;
        g = r;
        b = !s1_q.active ? 2'd0 : s1_q.vis ? {1'b0, lvl[1]} : {1'b0, s1_q.chk};
        uo_d           = '0;
        uo_d[UO_HSYNC] = s1_q.hs;
        uo_d[UO_VSYNC] = s1_q.vs;
        uo_d[UO_R1]    = r[1];
        uo_d[UO_R0]    = r[0];
        uo_d[UO_G1]    = g[1];
        uo_d[UO_G0]    = g[0];
        uo_d[UO_B1]    = b[1];
        uo_d[UO_B0]    = b[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= S1_RST;
            uo_q     <= 8'h88;
            scroll_q <= '0;
        end else begin
            s1_q     <= s1_d;
            uo_q     <= uo_d;
            scroll_q <= scroll_d;
        end
    end

    assign bus.uo_out = uo_q;

endmodule

// File: tb/tb_donut_pixel_out.sv
// tb_donut_pixel_out: randomized scoreboard bench for donut_pixel_out against a pixel-rule reference model.
module tb_donut_pixel_out;

    localparam int HD = 40;
    localparam int HT = 50;
    localparam int VD = 12;
    localparam int VT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    donut_pixel_out_if bus ();

    donut_pixel_out #(.H_DISPLAY(HD), .H_TOTAL(HT), .V_DISPLAY(VD), .V_TOTAL(VT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int scroll_m = 0;
    logic in_rst = 1'b0;
    logic [7:0] q[$];
    bit [3:0] bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic logic [7:0] expect_px(int h, int v, bit hs, bit vs, bit vis, int luma, int scr);
        int lvl;
        logic [1:0] r, g, b;
        bit chk;
        lvl = luma / 16 + (((luma % 16) > bay[v % 4][(h / 4) % 4]) ? 1 : 0);
        if (lvl > 3) lvl = 3;
        chk = 1'(((h / 32) % 32 + scr) % 2) ^ 1'((v / 32) % 2);
        if (!(h < HD && v < VD)) begin
            r = 0; g = 0; b = 0;
        end else if (vis && h < HD - 8) begin
            r = 2'(lvl); g = 2'(lvl); b = 2'(lvl / 2);
        end else begin
            r = 0; g = 0; b = {1'b0, chk};
        end
        return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    endfunction

    initial forever begin
        @(posedge clk);
        in_rst = !rst_n;
        if (!rst_n) begin
            foreach (q[i]) q[i] = 8'h88;
            q.push_back(8'h88);
            scroll_m = 0;
        end else begin
            q.push_back(expect_px(int'(bus.h_count), int'(bus.v_count), bus.hsync_n, bus.vsync_n,
                                  bus.donut_visible, int'(bus.donut_luma), scroll_m));
            if (int'(bus.h_count) == HT - 1 && int'(bus.v_count) == VT - 1) scroll_m = (scroll_m + 1) % 32;
        end
    end

    initial forever begin
        logic [7:0] exp_w;
        @(negedge clk);
        if (q.size() >= 2) begin
            exp_w = q.pop_front();
            checks++;
            if (bus.uo_out !== exp_w) begin
                errors++;
                $display("FAIL uo_out t=%0t got %h want %h", $time, bus.uo_out, exp_w);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (in_rst) begin
            checks++;
            if (bus.uo_out !== 8'h88 || dut.scroll_q !== 5'd0) begin
                errors++;
                $display("FAIL reset t=%0t uo_out %h scroll %0d", $time, bus.uo_out, dut.scroll_q);
            end
        end
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL timeout: run did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic drive(int h, int v, bit hs, bit vs, bit vis, int luma);
        @(negedge clk);
        bus.h_count       = 11'(h);
        bus.v_count       = 10'(v);
        bus.hsync_n       = hs;
        bus.vsync_n       = vs;
        bus.donut_visible = vis;
        bus.donut_luma    = 6'(luma);
    endtask

    task automatic drive_rand();
        bit wrap;
        wrap = ($urandom_range(0, 9) == 0);
        drive(wrap ? HT - 1 : int'($urandom_range(0, 2047)), wrap ? VT - 1 : int'($urandom_range(0, 1023)),
              1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 63)));
    endtask

    initial begin
        bus.h_count = '0; bus.v_count = '0; bus.hsync_n = 1'b1; bus.vsync_n = 1'b1;
        bus.donut_visible = 1'b0; bus.donut_luma = '0;
        repeat (5) drive_rand();
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 1, 21);
        drive(12, 1, 1, 1, 1, 21);
        for (int by = 0; by < 4; by++)
            for (int bx = 0; bx < 4; bx++)
                drive(bx * 4, by, 1, 1, 1, 63);
        drive(HD - 8, 0, 1, 1, 1, 63);
        drive(HD - 9, 0, 1, 1, 1, 63);
        drive(HD, 0, 1, 1, 1, 63);
        drive(0, VD, 1, 1, 1, 63);
        repeat (400) drive_rand();
        rst_n = 1'b0;
        repeat (3) drive_rand();
        rst_n = 1'b1;
        for (int f = 0; f < 33; f++)
            for (int v = 0; v < VT; v++)
                for (int h = 0; h < HT; h++)
                    drive(h, v, !(h >= HD + 2 && h < HD + 7), !(v >= VD + 1 && v < VD + 3),
                          1'($urandom), int'($urandom_range(0, 63)));
        repeat (4) drive(0, 0, 1, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
